bsg_mem_byte_access_ctrl: RTL and testbench
===========================================

Name: bsg_mem_byte_access_ctrl

Overview:
- Initiator for a 1-port synchronous byte-masked SRAM (manycore DMEM / vcache data-mem style).
- Accepts byte-addressed load/store requests of size 1/2/4/8 bytes on a valid/ready port.
- Drives the memory's v/w/addr/data/write-mask pins, lane-aligns store data and expands byte masks.
- Captures the sync read data one cycle after issue, extracts and sign/zero-extends it, and returns it through a backpressured response buffer.

Parameters:
- els_p, 1024, memory depth in words
- data_width_p, 32, memory word width; multiple of 8, maximum 64
- resp_els_p, 2, response buffer depth; must be >= 2
- addr_width_lp, clog2(els_p), memory word address width
- mask_width_lp, data_width_p/8, byte-mask width
- boff_width_lp, clog2(mask_width_lp), byte-offset width
- baddr_width_lp, addr_width_lp+boff_width_lp, request byte-address width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- v_i  in  1  request valid
- ready_o  out  1  request ready; handshake = v_i & ready_o
- w_i  in  1  1 = store, 0 = load
- addr_i  in  baddr_width_lp  byte address
- size_i  in  2  log2 of access bytes
- signed_i  in  1  sign-extend load result
- data_i  in  data_width_p  store data, LSB-aligned
- v_o  out  1  response valid (loads only)
- yumi_i  in  1  response consumed; legal only when v_o=1
- data_o  out  data_width_p  load data, extended
- err_o  out  1  response is for a misaligned load
- misaligned_o  out  1  sticky: any misaligned request seen
- mem_v_o  out  1  memory v_i
- mem_w_o  out  1  memory w_i
- mem_addr_o  out  addr_width_lp  memory word address
- mem_data_o  out  data_width_p  memory write data
- mem_w_mask_o  out  mask_width_lp  memory byte write mask
- mem_data_i  in  data_width_p  memory data_o

Behaviour:
- Reset (async assert, sync deassert):
  - Buffer empty; pending-read flag cleared; misaligned_o=0.
  - v_o=0, err_o=0, data_o=0, mem_v_o=0, ready_o=1 after reset release.
- Credit rule: ready_o = (buffer_count + read_pending) < resp_els_p.
  - ready_o never depends on v_i or w_i.
  - A yumi in the same cycle does not free a credit until the next cycle.
- Alignment:
  - Aligned means addr_i mod 2^size_i == 0 and 2^size_i <= mask_width_lp.
  - Otherwise the request is misaligned.
- Issue (combinational in the accept cycle t):
  - mem_v_o = accept & aligned; mem_w_o = w_i; mem_addr_o = addr_i >> boff_width_lp.
  - Stores:
    - mem_w_mask_o has 2^size_i ones starting at bit off = addr_i[boff-1:0].
    - mem_data_o = data_i replicated per size, so the addressed lanes carry data_i.
    - Other lanes are don't-care, and their mask bits are 0.
  - Loads: mem_w_mask_o = 0.
- Load capture:
  - Cycle t: set read_pending and register offset, size, signed and err.
  - Cycle t+1: extract bytes [off, off+2^size) of mem_data_i, shift them to LSB and extend (sign when signed_i, else zero). Push the result into the buffer at the end of t+1; clear read_pending.
  - v_o is asserted from cycle t+2. Fixed load-to-response latency is 2 cycles.
- Misaligned load:
  - No memory access; still occupies a slot with the same 2-cycle timing.
  - Response data_o=0, err_o=1.
- Misaligned store: dropped with no memory access and no response.
- misaligned_o is set on the first misaligned accept and held until reset.
- Ordering: responses are returned in request order.
- Buffer:
  - FIFO with simultaneous push and pop allowed.
  - Overflow is impossible by the credit rule.
  - yumi_i when v_o=0 is an assertion error.
- Stores:
  - Take effect in the memory at the issue edge and generate no response.
  - A load issued the next cycle to the same word observes the store.
- Reset mid-operation: pending and buffered responses are discarded, the memory transaction in flight is abandoned, and all outputs return to reset values asynchronously.

Decomposition:
- Shared package bsg_mem_byte_access_pkg:
  - size enum: e_byte=0, e_half=1, e_word=2, e_dword=3.
  - Response struct {err, data}.
  - Function for size-to-mask expansion.
- Sub-module bsg_mem_byte_lane_align: combinational store-replicate/mask-generate and load-extract/extend, parameterized by data_width_p.
- Top level holds the pending register, credit counter and response FIFO (bsg_fifo_1r1w_small).

Test Plan (data_width_p=32):
- Reset release -> ready_o=1, v_o=0, mem_v_o=0, misaligned_o=0; holding reset_n_i low mid-burst clears v_o immediately.
- Store byte at addr 0x6, data_i=0xAB -> mem_v_o=1, mem_w_o=1, mem_addr_o=1, mem_w_mask_o=4'b0100, mem_data_o[23:16]=0xAB.
- Signed load-byte at addr 0x6 with mem_data_i=0x12AB3456 at t+1 -> at t+2 v_o=1, data_o=0xFFFFFFAB, err_o=0; the unsigned variant gives 0x000000AB.
- Three back-to-back loads with yumi_i=0 -> two accepted, ready_o=0 on the third; after a yumi, ready_o=1 next cycle; data returns in order with no loss.
- Load-word at addr 0x2 -> mem_v_o=0; at t+2 v_o=1, err_o=1, data_o=0; misaligned_o=1 and stays set.
- Half-word store of 0xBEEF at addr 0x2, then load-half at addr 0x2 the next cycle -> mask 4'b1100; response data_o=0x0000BEEF (zero-extended).

Source files
------------

// File: rtl/bsg_mem_byte_access_pkg.sv
// Shared types and helpers for the byte-access SRAM initiator.
//   bsg_mem_size_e  : log2 of the access size in bytes
//   bsg_mem_resp_s  : one response-buffer entry {err, data}; data is sized for
//                     the widest supported memory word and zero above the real width
//   size_to_mask    : 2^size contiguous ones starting at bit 0
package bsg_mem_byte_access_pkg;

  localparam int unsigned max_data_width_gp = 64;

  typedef enum logic [1:0] {
    e_byte  = 2'd0,
    e_half  = 2'd1,
    e_word  = 2'd2,
    e_dword = 2'd3
  } bsg_mem_size_e;

  typedef struct packed {
    logic                         err;
    logic [max_data_width_gp-1:0] data;
  } bsg_mem_resp_s;

  function automatic logic [7:0] size_to_mask(input logic [1:0] size);
    logic [7:0] mask;
    unique case (size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO with simultaneous push and pop.
//   v_i/data_i   : push (caller guarantees space)
//   yumi_i       : pop of the head entry (caller guarantees v_o)
//   v_o/data_o   : head entry valid / value
//   count_o      : current occupancy
module bsg_fifo_1r1w_small #(
  parameter  int unsigned width_p        = 8,
  parameter  int unsigned els_p          = 2,
  localparam int unsigned ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  input  logic                      yumi_i,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  output logic [count_width_lp-1:0] count_o
);

  logic [width_p-1:0]        mem_r [els_p];
  logic [ptr_width_lp-1:0]   wptr_r, rptr_r;
  logic [count_width_lp-1:0] count_r;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (32'(p) == els_p - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < els_p; i++) mem_r[i] <= '0;
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (v_i) begin
        mem_r[wptr_r] <= data_i;
        wptr_r        <= ptr_inc(wptr_r);
      end
      if (yumi_i) rptr_r <= ptr_inc(rptr_r);
      unique case ({v_i, yumi_i})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign count_o = count_r;

endmodule

// File: rtl/bsg_mem_byte_lane_align.sv
// Combinational byte-lane steering for a byte-masked SRAM word.
//   Store side: replicates the low 2^size bytes of st_data_i across the word
//               and builds the write mask for the addressed lanes.
//   Load side : shifts bytes [off, off+2^size) of ld_data_i to the LSB and
//               sign- or zero-extends to the full word.
// Requires data_width_p >= 16 so the byte offset is at least one bit wide.
module bsg_mem_byte_lane_align
  import bsg_mem_byte_access_pkg::*;
#(
  parameter  int unsigned data_width_p  = 32,
  localparam int unsigned mask_width_lp = data_width_p / 8,
  localparam int unsigned boff_width_lp = $clog2(mask_width_lp)
) (
  input  logic [boff_width_lp-1:0] st_off_i,
  input  logic [1:0]               st_size_i,
  input  logic [data_width_p-1:0]  st_data_i,
  output logic [data_width_p-1:0]  st_data_o,
  output logic [mask_width_lp-1:0] st_mask_o,

  input  logic [boff_width_lp-1:0] ld_off_i,
  input  logic [1:0]               ld_size_i,
  input  logic                     ld_signed_i,
  input  logic [data_width_p-1:0]  ld_data_i,
  output logic [data_width_p-1:0]  ld_data_o
);

  logic [2:0]               idx_mask;
  logic [mask_width_lp-1:0] base_mask;
  logic [data_width_p-1:0]  shifted, keep;
  logic                     sign;

  // Replication by (lane mod 2^size): every aligned slot of the access size
  // carries the same data, so the addressed one is correct for any offset.
  assign idx_mask = 3'((32'd1 << st_size_i) - 32'd1);

  always_comb begin
    st_data_o = '0;
    for (int unsigned i = 0; i < mask_width_lp; i++) begin
      st_data_o[8*i +: 8] = st_data_i[8*(i & 32'(idx_mask)) +: 8];
    end
  end

  assign base_mask = mask_width_lp'(size_to_mask(st_size_i));
  assign st_mask_o = base_mask << st_off_i;

  // keep marks the bits of the accessed field; its top set bit is the sign.
  assign shifted   = ld_data_i >> {ld_off_i, 3'b000};
  assign keep      = ~({data_width_p{1'b1}} << (32'd8 << ld_size_i));
  assign sign      = |(shifted & keep & ~(keep >> 1));
  assign ld_data_o = (shifted & keep) | ({data_width_p{ld_signed_i & sign}} & ~keep);

endmodule

// File: rtl/bsg_mem_byte_access_ctrl.sv
// Byte-addressed load/store initiator for a 1-port synchronous byte-masked SRAM.
//   v_i/ready_o/w_i/addr_i/size_i/signed_i/data_i : request port
//   v_o/yumi_i/data_o/err_o                        : load response port (in order)
//   misaligned_o                                   : sticky misaligned-request flag
//   mem_*                                          : SRAM pins (read data one cycle after issue)
// Loads respond exactly two cycles after accept; a credit covers both the read
// in flight and the buffered entries, so the response FIFO cannot overflow.
module bsg_mem_byte_access_ctrl
  import bsg_mem_byte_access_pkg::*;
#(
  parameter  int unsigned els_p          = 1024,
  parameter  int unsigned data_width_p   = 32,
  parameter  int unsigned resp_els_p     = 2,
  localparam int unsigned addr_width_lp  = $clog2(els_p),
  localparam int unsigned mask_width_lp  = data_width_p / 8,
  localparam int unsigned boff_width_lp  = $clog2(mask_width_lp),
  localparam int unsigned baddr_width_lp = addr_width_lp + boff_width_lp
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic                      v_i,
  output logic                      ready_o,
  input  logic                      w_i,
  input  logic [baddr_width_lp-1:0] addr_i,
  input  logic [1:0]                size_i,
  input  logic                      signed_i,
  input  logic [data_width_p-1:0]   data_i,

  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [data_width_p-1:0]   data_o,
  output logic                      err_o,
  output logic                      misaligned_o,

  output logic                      mem_v_o,
  output logic                      mem_w_o,
  output logic [addr_width_lp-1:0]  mem_addr_o,
  output logic [data_width_p-1:0]   mem_data_o,
  output logic [mask_width_lp-1:0]  mem_w_mask_o,
  input  logic [data_width_p-1:0]   mem_data_i
);

  localparam int unsigned count_width_lp = $clog2(resp_els_p + 1);

  logic                      accept, aligned;
  logic [boff_width_lp-1:0]  off, off_mask;
  logic [mask_width_lp-1:0]  st_mask;
  logic [data_width_p-1:0]   st_data, ld_data;

  logic                      rd_pending_r, rd_signed_r, rd_err_r, misaligned_r;
  logic [boff_width_lp-1:0]  rd_off_r;
  bsg_mem_size_e             rd_size_r;

  logic [count_width_lp-1:0] fifo_count;
  bsg_mem_resp_s             push_resp, head_resp;

  assign off      = addr_i[boff_width_lp-1:0];
  assign off_mask = boff_width_lp'((32'd1 << size_i) - 32'd1);
  assign aligned  = ((off & off_mask) == '0) && (32'(size_i) <= boff_width_lp);

  // Registered count only: a pop this cycle frees its credit next cycle.
  // Gated by reset so nothing is accepted or issued while reset is held.
  assign ready_o = reset_n_i && ((32'(fifo_count) + 32'(rd_pending_r)) < resp_els_p);
  assign accept  = v_i & ready_o;

  bsg_mem_byte_lane_align #(.data_width_p(data_width_p)) lane_align (
    .st_off_i    (off),
    .st_size_i   (size_i),
    .st_data_i   (data_i),
    .st_data_o   (st_data),
    .st_mask_o   (st_mask),
    .ld_off_i    (rd_off_r),
    .ld_size_i   (rd_size_r),
    .ld_signed_i (rd_signed_r),
    .ld_data_i   (mem_data_i),
    .ld_data_o   (ld_data)
  );

  assign mem_v_o      = accept & aligned;
  assign mem_w_o      = w_i;
  assign mem_addr_o   = addr_i[baddr_width_lp-1:boff_width_lp];
  assign mem_data_o   = st_data;
  assign mem_w_mask_o = (w_i && aligned) ? st_mask : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_pending_r <= 1'b0;
      rd_off_r     <= '0;
      rd_size_r    <= e_byte;
      rd_signed_r  <= 1'b0;
      rd_err_r     <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      rd_pending_r <= accept & ~w_i;
      if (accept & ~w_i) begin
        rd_off_r    <= off;
        rd_size_r   <= bsg_mem_size_e'(size_i);
        rd_signed_r <= signed_i;
        rd_err_r    <= ~aligned;
      end
      if (accept & ~aligned) misaligned_r <= 1'b1;
    end
  end

  assign misaligned_o = misaligned_r;

  always_comb begin
    push_resp     = '0;
    push_resp.err = rd_err_r;
    if (!rd_err_r) push_resp.data[data_width_p-1:0] = ld_data;
  end

  bsg_fifo_1r1w_small #(
    .width_p ($bits(bsg_mem_resp_s)),
    .els_p   (resp_els_p)
  ) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (rd_pending_r),
    .data_i    (push_resp),
    .yumi_i    (yumi_i),
    .v_o       (v_o),
    .data_o    (head_resp),
    .count_o   (fifo_count)
  );

  assign data_o = head_resp.data[data_width_p-1:0];
  assign err_o  = head_resp.err;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

  // Lanes above data_width_p are never written, so buffered entries keep them zero.
  resp_upper_zero: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    v_o |-> ((head_resp.data >> data_width_p) == '0));

endmodule

// File: tb/tb_bsg_mem_byte_access_ctrl.sv
module tb_bsg_mem_byte_access_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned ELS = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v_i = 1'b0, w_i = 1'b0, signed_i = 1'b0, yumi_i = 1'b0;
  logic [11:0] addr_i = '0;
  logic [1:0]  size_i = '0;
  logic [31:0] data_i = '0;
  logic        ready_o, v_o, err_o, misaligned_o, mem_v_o, mem_w_o;
  logic [31:0] data_o, mem_data_o, mem_data_i;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_w_mask_o;

  always #5 clk = ~clk;

  bsg_mem_byte_access_ctrl #(.els_p(ELS), .data_width_p(DW), .resp_els_p(2)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .v_i(v_i), .ready_o(ready_o), .w_i(w_i), .addr_i(addr_i), .size_i(size_i),
    .signed_i(signed_i), .data_i(data_i),
    .v_o(v_o), .yumi_i(yumi_i), .data_o(data_o), .err_o(err_o), .misaligned_o(misaligned_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
  );

  // Synchronous byte-masked SRAM driven only by the DUT pins.
  logic [31:0] sram [0:ELS-1];
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) begin
        for (int i = 0; i < 4; i++)
          if (mem_w_mask_o[i]) sram[mem_addr_o][8*i +: 8] <= mem_data_o[8*i +: 8];
      end else begin
        mem_data_i <= sram[mem_addr_o];
      end
    end
  end

  // Reference model: flat byte memory plus a queue of expected responses,
  // each tagged with the cycle from which it must be visible.
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          rc;
  } exp_t;

  logic [7:0] ref_b [0:4*ELS-1];
  exp_t       exp_q[$];
  bit         exp_mis = 1'b0;
  int         cyc = 0;
  int         tests = 0, fails = 0;

  logic        e_ready, e_vo, e_mem_v, e_acc, e_al, e_mis;
  exp_t        e_head;
  logic [3:0]  e_mask;
  logic [31:0] e_wdata, e_wcare;
  logic [9:0]  e_maddr;

  always @(posedge clk) cyc++;

  // Applies one cycle of inputs at the negedge and advances the model.
  task automatic drive(input logic v, input logic w, input logic [11:0] a, input logic [1:0] sz,
                       input logic sg, input logic [31:0] d, input logic yreq);
    int nb, off;
    longint val;
    @(negedge clk);
    e_ready = (exp_q.size() < 2);
    e_vo    = (exp_q.size() > 0) && (exp_q[0].rc <= cyc);
    e_head  = e_vo ? exp_q[0] : '{data: 32'h0, err: 1'b0, rc: 0};
    e_mis   = exp_mis;
    v_i = v; w_i = w; addr_i = a; size_i = sz; signed_i = sg; data_i = d;
    yumi_i = yreq && e_vo;
    nb = 1 << sz;
    off = int'(a) % 4;
    e_acc   = v && e_ready;
    e_al    = ((int'(a) % nb) == 0) && (nb <= 4);
    e_mem_v = e_acc && e_al;
    e_maddr = a[11:2];
    e_mask = '0; e_wdata = '0; e_wcare = '0;
    if (e_mem_v && w) begin
      for (int k = 0; k < nb; k++) begin
        e_mask[off+k]           = 1'b1;
        e_wdata[8*(off+k) +: 8] = d[8*k +: 8];
        e_wcare[8*(off+k) +: 8] = 8'hFF;
        ref_b[int'(a)+k]        = d[8*k +: 8];
      end
    end
    if (e_acc && !w) begin
      if (e_al) begin
        val = 0;
        for (int k = 0; k < nb; k++) val = val | (longint'(ref_b[int'(a)+k]) << (8*k));
        if (sg && val[8*nb-1]) val = val | -(longint'(1) << (8*nb));
        exp_q.push_back('{data: val[31:0], err: 1'b0, rc: cyc + 2});
      end else begin
        exp_q.push_back('{data: 32'h0, err: 1'b1, rc: cyc + 2});
      end
    end
    if (e_acc && !e_al) exp_mis = 1'b1;
    if (yumi_i) void'(exp_q.pop_front());
    #1;
  endtask

  task automatic idle(input logic yreq);
    drive(1'b0, 1'b0, 12'h0, 2'd0, 1'b0, 32'h0, yreq);
  endtask

  task automatic test_reset();
    v_i = 1'b1; w_i = 1'b1; size_i = 2'd2;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (mem_v_o !== 1'b0) begin fails++; $display("FAIL rst_hold_mem_v: got %b want 0", mem_v_o); end
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL rst_hold_v_o: got %b want 0", v_o); end
    @(negedge clk);
    v_i = 1'b0; w_i = 1'b0; size_i = 2'd0; reset_n = 1'b1;
    #1;
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL rst_v_o: got %b want 0", v_o); end
    tests++; if (mem_v_o !== 1'b0) begin fails++; $display("FAIL rst_mem_v: got %b want 0", mem_v_o); end
    tests++; if (misaligned_o !== 1'b0) begin fails++; $display("FAIL rst_misaligned: got %b want 0", misaligned_o); end
    tests++; if (data_o !== 32'h0 || err_o !== 1'b0) begin fails++; $display("FAIL rst_resp: got %h/%b want 0/0", data_o, err_o); end
  endtask

  task automatic test_store_byte();
    drive(1'b1, 1'b1, 12'h006, 2'd0, 1'b0, 32'h000000AB, 1'b0);
    tests++; if (mem_v_o !== 1'b1 || mem_w_o !== 1'b1) begin fails++; $display("FAIL sb_vw: got %b%b want 11", mem_v_o, mem_w_o); end
    tests++; if (mem_addr_o !== 10'd1) begin fails++; $display("FAIL sb_addr: got %0d want 1", mem_addr_o); end
    tests++; if (mem_w_mask_o !== 4'b0100) begin fails++; $display("FAIL sb_mask: got %b want 0100", mem_w_mask_o); end
    tests++; if (mem_data_o[23:16] !== 8'hAB) begin fails++; $display("FAIL sb_lane: got %h want ab", mem_data_o[23:16]); end
  endtask

  task automatic test_load_byte();
    drive(1'b1, 1'b1, 12'h004, 2'd2, 1'b0, 32'h12AB3456, 1'b0);
    drive(1'b1, 1'b0, 12'h006, 2'd0, 1'b1, 32'h0, 1'b0);
    tests++; if (mem_v_o !== 1'b1 || mem_w_o !== 1'b0 || mem_w_mask_o !== 4'b0000) begin
      fails++; $display("FAIL lb_issue: got v%b w%b m%b want v1 w0 m0000", mem_v_o, mem_w_o, mem_w_mask_o); end
    idle(1'b0);
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL lb_early: got v_o=%b want 0", v_o); end
    idle(1'b1);
    tests++; if (v_o !== 1'b1 || data_o !== 32'hFFFFFFAB || err_o !== 1'b0) begin
      fails++; $display("FAIL lb_signed: got v%b %h e%b want v1 ffffffab e0", v_o, data_o, err_o); end
    drive(1'b1, 1'b0, 12'h006, 2'd0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    tests++; if (v_o !== 1'b1 || data_o !== 32'h000000AB || err_o !== 1'b0) begin
      fails++; $display("FAIL lb_unsigned: got v%b %h e%b want v1 000000ab e0", v_o, data_o, err_o); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 12'h010, 2'd2, 1'b0, 32'hA1A2A3A4, 1'b0);
    drive(1'b1, 1'b1, 12'h014, 2'd2, 1'b0, 32'hB1B2B3B4, 1'b0);
    drive(1'b1, 1'b1, 12'h018, 2'd2, 1'b0, 32'hC1C2C3C4, 1'b0);
    drive(1'b1, 1'b0, 12'h010, 2'd2, 1'b0, 32'h0, 1'b0);
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready0: got %b want 1", ready_o); end
    drive(1'b1, 1'b0, 12'h014, 2'd2, 1'b0, 32'h0, 1'b0);
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %b want 1", ready_o); end
    drive(1'b1, 1'b0, 12'h018, 2'd2, 1'b0, 32'h0, 1'b0);
    tests++; if (ready_o !== 1'b0 || mem_v_o !== 1'b0) begin fails++; $display("FAIL b2b_full: got ready=%b mem_v=%b want 0 0", ready_o, mem_v_o); end
    idle(1'b1);
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL b2b_yumi_credit: got %b want 0", ready_o); end
    tests++; if (v_o !== 1'b1 || data_o !== 32'hA1A2A3A4) begin fails++; $display("FAIL b2b_first: got v%b %h want v1 a1a2a3a4", v_o, data_o); end
    idle(1'b0);
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL b2b_credit_back: got %b want 1", ready_o); end
    tests++; if (v_o !== 1'b1 || data_o !== 32'hB1B2B3B4) begin fails++; $display("FAIL b2b_second: got v%b %h want v1 b1b2b3b4", v_o, data_o); end
    idle(1'b1);
    idle(1'b0);
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL b2b_extra: got v_o=%b want 0", v_o); end
    drive(1'b1, 1'b0, 12'h018, 2'd2, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    tests++; if (v_o !== 1'b1 || data_o !== 32'hC1C2C3C4) begin fails++; $display("FAIL b2b_retry: got v%b %h want v1 c1c2c3c4", v_o, data_o); end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b0, 12'h002, 2'd2, 1'b0, 32'h0, 1'b0);
    tests++; if (mem_v_o !== 1'b0) begin fails++; $display("FAIL mis_mem_v: got %b want 0", mem_v_o); end
    tests++; if (misaligned_o !== 1'b0) begin fails++; $display("FAIL mis_before: got %b want 0", misaligned_o); end
    idle(1'b0);
    tests++; if (misaligned_o !== 1'b1) begin fails++; $display("FAIL mis_sticky_set: got %b want 1", misaligned_o); end
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL mis_early: got v_o=%b want 0", v_o); end
    idle(1'b1);
    tests++; if (v_o !== 1'b1 || err_o !== 1'b1 || data_o !== 32'h0) begin
      fails++; $display("FAIL mis_resp: got v%b e%b %h want v1 e1 00000000", v_o, err_o, data_o); end
    drive(1'b1, 1'b1, 12'h001, 2'd1, 1'b0, 32'h0000FFFF, 1'b0);
    tests++; if (mem_v_o !== 1'b0) begin fails++; $display("FAIL mis_store_mem_v: got %b want 0", mem_v_o); end
    drive(1'b1, 1'b0, 12'h000, 2'd3, 1'b0, 32'h0, 1'b0);
    tests++; if (mem_v_o !== 1'b0) begin fails++; $display("FAIL mis_dword_mem_v: got %b want 0", mem_v_o); end
    idle(1'b0);
    idle(1'b1);
    tests++; if (v_o !== 1'b1 || err_o !== 1'b1) begin fails++; $display("FAIL mis_dword_resp: got v%b e%b want v1 e1", v_o, err_o); end
    repeat (3) idle(1'b0);
    tests++; if (v_o !== 1'b0 || misaligned_o !== 1'b1) begin
      fails++; $display("FAIL mis_hold: got v%b mis%b want v0 mis1", v_o, misaligned_o); end
  endtask

  task automatic test_half();
    drive(1'b1, 1'b1, 12'h002, 2'd1, 1'b0, 32'h0000BEEF, 1'b0);
    tests++; if (mem_v_o !== 1'b1 || mem_w_mask_o !== 4'b1100) begin
      fails++; $display("FAIL sh_mask: got v%b %b want v1 1100", mem_v_o, mem_w_mask_o); end
    tests++; if (mem_data_o[31:16] !== 16'hBEEF) begin fails++; $display("FAIL sh_lane: got %h want beef", mem_data_o[31:16]); end
    drive(1'b1, 1'b0, 12'h002, 2'd1, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    tests++; if (v_o !== 1'b1 || data_o !== 32'h0000BEEF || err_o !== 1'b0) begin
      fails++; $display("FAIL lh_resp: got v%b %h e%b want v1 0000beef e0", v_o, data_o, err_o); end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [1:0]  sz;
    for (int n = 0; n < 600; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 12'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7) a = a & ~12'((1 << sz) - 1);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, a, sz,
            1'($urandom), $urandom, $urandom_range(0, 9) < 6);
      tests++; if (ready_o !== e_ready) begin fails++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, ready_o, e_ready); end
      tests++; if (v_o !== e_vo) begin fails++; $display("FAIL rnd_v_o@%0d: got %b want %b", cyc, v_o, e_vo); end
      if (e_vo) begin
        tests++; if (data_o !== e_head.data || err_o !== e_head.err) begin
          fails++; $display("FAIL rnd_resp@%0d: got %h e%b want %h e%b", cyc, data_o, err_o, e_head.data, e_head.err); end
      end
      tests++; if (misaligned_o !== e_mis) begin fails++; $display("FAIL rnd_mis@%0d: got %b want %b", cyc, misaligned_o, e_mis); end
      tests++; if (mem_v_o !== e_mem_v) begin fails++; $display("FAIL rnd_mem_v@%0d: got %b want %b", cyc, mem_v_o, e_mem_v); end
      if (e_mem_v) begin
        tests++; if (mem_w_o !== w_i || mem_addr_o !== e_maddr || mem_w_mask_o !== e_mask) begin
          fails++; $display("FAIL rnd_issue@%0d: got w%b a%0d m%b want w%b a%0d m%b",
                            cyc, mem_w_o, mem_addr_o, mem_w_mask_o, w_i, e_maddr, e_mask); end
        tests++; if ((mem_data_o & e_wcare) !== e_wdata) begin
          fails++; $display("FAIL rnd_wdata@%0d: got %h want %h (lanes %h)", cyc, mem_data_o & e_wcare, e_wdata, e_wcare); end
      end
    end
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      idle(1'b1);
      tests++; if (v_o !== e_vo || (e_vo && (data_o !== e_head.data || err_o !== e_head.err))) begin
        fails++; $display("FAIL rnd_drain@%0d: got v%b %h e%b want v%b %h e%b",
                          cyc, v_o, data_o, err_o, e_vo, e_head.data, e_head.err); end
    end
    idle(1'b0);
    tests++; if (v_o !== 1'b0 || exp_q.size() != 0) begin
      fails++; $display("FAIL rnd_empty: got v_o=%b pending=%0d want 0 0", v_o, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 12'h010, 2'd2, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 12'h003, 2'd1, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    tests++; if (v_o !== 1'b1) begin fails++; $display("FAIL mid_pre_v_o: got %b want 1", v_o); end
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_mis = 1'b0;
    tests++; if (v_o !== 1'b0 || err_o !== 1'b0 || data_o !== 32'h0) begin
      fails++; $display("FAIL mid_async: got v%b e%b %h want v0 e0 00000000", v_o, err_o, data_o); end
    tests++; if (misaligned_o !== 1'b0) begin fails++; $display("FAIL mid_mis_clr: got %b want 0", misaligned_o); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests++; if (ready_o !== 1'b1 || v_o !== 1'b0) begin fails++; $display("FAIL mid_release: got r%b v%b want r1 v0", ready_o, v_o); end
    drive(1'b1, 1'b0, 12'h014, 2'd2, 1'b1, 32'h0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    tests++; if (v_o !== 1'b1 || data_o !== e_head.data || err_o !== 1'b0) begin
      fails++; $display("FAIL mid_after: got v%b %h e%b want v1 %h e0", v_o, data_o, err_o, e_head.data); end
  endtask

  initial begin
    for (int i = 0; i < int'(ELS); i++) begin
      sram[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = sram[i][8*k +: 8];
    end
    test_reset();
    test_store_byte();
    test_load_byte();
    test_back_to_back();
    test_half();
    test_misaligned();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
